muxpga_cfg_loader: RTL and testbench
====================================

# muxpga_cfg_loader

Host-side driver for the differential mux-FPGA tile. It accepts a byte stream, serializes the configuration bitstream into 4-bit SHIFT commands and commits it with LATCH. It then drives evaluation vectors into the fabric and returns the sampled 8-bit fabric outputs. It sits between the test/SoC byte source and the tile's `{cmd[1:0], data[3:0]}` input pins.

## Interface
Parameters:
- `NIBBLES`, 16: configuration length in nibbles; must be even and ≥2; config phase takes `NIBBLES/2` bytes.
- `CAP_LAT`, 2: cycles from an EVAL command on the pins to the fabric-output sample; range 1–7.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a session; ignored while `busy`.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in 8 / `s_last` in 1: input byte stream; transfer when `s_valid & s_ready`.
- `cfg_cmd` out 2: tile command pins, registered.
- `cfg_data` out 4: tile data pins, registered.
- `fab_out` in 8: tile `io_out`.
- `cap_valid` out 1 / `cap_data` out 8: captured fabric result; one-cycle strobe, no backpressure.
- `busy` out 1: high from the cycle after `start` until return to IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: sticky; cleared by the next accepted `start` or by `rst`.

## Operation
- Command codes: NOP=00, SHIFT=01 (shift `cfg_data` into the chain), LATCH=10 (commit chain to the active config), EVAL=11 (apply `cfg_data` as fabric inputs).
- FSM states: IDLE, LOAD, COMMIT, RUN, DRAIN.
- IDLE: `cfg_cmd`=NOP, `s_ready`=0. On `start`, go to LOAD, clear `err`, zero the nibble counter.
- LOAD:
  - A byte is accepted only when no low nibble is pending.
  - The accepted byte emits SHIFT with `s_data[7:4]`, then SHIFT with `s_data[3:0]` on the following cycle.
  - The nibble counter increments on every SHIFT.
  - `s_last` on any byte other than byte `NIBBLES/2`: set `err`, shift nothing from that byte, return to IDLE. No LATCH is issued and no `done` pulse occurs.
  - `s_last` on the final config byte is ignored.
  - After SHIFT number `NIBBLES`, go to COMMIT.
- COMMIT: one cycle of `cfg_cmd`=LATCH, `cfg_data`=0, `s_ready`=0, then RUN.
- RUN:
  - `s_ready`=1.
  - Each accepted byte emits one EVAL cycle with `s_data[3:0]`; `s_data[7:4]` is ignored.
  - Cycles with no accepted byte emit NOP.
  - Each EVAL launches a capture token. `fab_out` is sampled `CAP_LAT` cycles after EVAL appears on the pins and presented with `cap_valid` on the next cycle.
  - A byte with `s_last` still issues its EVAL, then the FSM goes to DRAIN.
- DRAIN: NOP, `s_ready`=0. When no capture tokens remain, go to IDLE with `done`=1 for one cycle.
- `start` outside IDLE: ignored.
- `rst` mid-session: the next edge forces IDLE and NOP with all tokens flushed. LATCH is never emitted from a partial load.

## Timing
- Reset values:
  - `cfg_cmd`=00, `cfg_data`=0
  - `s_ready`, `busy`, `done`, `err`, `cap_valid` = 0
  - `cap_data`=0
- `start` at edge t: `busy`=1 and `s_ready`=1 from t+1.
- LOAD byte accepted at edge t: high-nibble SHIFT visible t+1 to t+2, low-nibble SHIFT visible t+2 to t+3. `s_ready` is low in cycle t+1, giving a throughput of 1 byte per 2 cycles.
- LATCH is visible the cycle after the last SHIFT.
- RUN: 1 vector per cycle. EVAL is visible from edge e+1 if accepted at e. `cap_valid` pulses at edge e+1+`CAP_LAT`+1. Results come out in issue order, up to `CAP_LAT`+1 outstanding.
- `done` rises the same edge IDLE is entered, which is one cycle after the last `cap_valid`.

## Structure
- `muxpga_pkg`:
  - `cmd_t` enum (NOP/SHIFT/LATCH/EVAL) with the 2-bit codes above.
  - `state_t` enum.
  - Shared with the fabric TB and tile wrapper.
- Sub-module `muxpga_cap_pipe`: `CAP_LAT`+1-deep token shift register. It holds the valid bit only; it does the `fab_out` sampling and reports an `empty` flag for DRAIN.

## Test plan
- `NIBBLES`=4, stream 0xA5 then 0x3C after `start` -> pins show SHIFT A, SHIFT 5, SHIFT 3, SHIFT C, LATCH, then RUN with `s_ready`=1.
- After config, vectors 0x01, 0x02, 0x0F (last) back-to-back with `fab_out` driven as a function of the vector -> three EVALs on consecutive cycles. `cap_data` matches the model at EVAL+`CAP_LAT`+1 in order, then `done` fires one cycle after the third `cap_valid`.
- `s_last` on config byte 1 of 2 -> `err`=1, no LATCH ever on the pins, IDLE, `done` stays 0. The next `start` clears `err`.
- `s_valid` toggling 1/0 in LOAD and RUN -> NOP on idle cycles; nibble order and count are unchanged.
- `rst` asserted mid-LOAD (after 1 nibble) -> `cfg_cmd`=NOP on the next cycle, all outputs at reset values, no LATCH. A subsequent full load succeeds.
- `start` pulsed during RUN -> ignored; the session and results are unaffected.

Source files
------------

// File: rtl/muxpga_pkg.sv
// muxpga_pkg: tile command codes and loader FSM states shared by loader, tile wrapper and fabric bench
package muxpga_pkg;
  typedef enum logic [1:0] {NOP = 2'b00, SHIFT = 2'b01, LATCH = 2'b10, EVAL = 2'b11} cmd_t;
  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, RUN, DRAIN} state_t;
endpackage

// File: rtl/muxpga_cap_pipe.sv
// muxpga_cap_pipe: EVAL token delay line that samples fab_out_i after CAP_LAT cycles and presents it a cycle later
module muxpga_cap_pipe #(
  parameter int CAP_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       launch_i,
  input  logic [7:0] fab_out_i,
  output logic       cap_valid_o,
  output logic [7:0] cap_data_o,
  output logic       empty_o
);
  logic [CAP_LAT:0] tok_q;
  logic [7:0]       samp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_q       <= '0;
      samp_q      <= '0;
      cap_valid_o <= 1'b0;
      cap_data_o  <= '0;
    end else begin
      tok_q       <= {tok_q[CAP_LAT-1:0], launch_i};
      samp_q      <= tok_q[CAP_LAT-1] ? fab_out_i : samp_q;
      cap_valid_o <= tok_q[CAP_LAT];
      cap_data_o  <= tok_q[CAP_LAT] ? samp_q : cap_data_o;
    end
  end
  assign empty_o = ~|tok_q;
endmodule

// File: rtl/muxpga_cfg_loader.sv
// muxpga_cfg_loader: turns a byte stream into SHIFT/LATCH config and EVAL vectors for the mux-FPGA tile, returning captures
module muxpga_cfg_loader
  import muxpga_pkg::*;
#(
  parameter int NIBBLES = 16,
  parameter int CAP_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic [1:0] cfg_cmd,
  output logic [3:0] cfg_data,
  input  logic [7:0] fab_out,
  output logic       cap_valid,
  output logic [7:0] cap_data,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(NIBBLES + 1);
  state_t        state_q;
  cmd_t          cmd_q;
  logic [3:0]    data_q, low_q;
  logic          pend_q, done_q, err_q;
  logic [CW-1:0] cnt_q;
  logic          acc, empty, final_byte;
  assign s_ready    = (state_q == LOAD && !pend_q) || state_q == RUN;
  assign acc        = s_valid && s_ready;
  assign final_byte = cnt_q == CW'(NIBBLES - 2);
  assign busy       = state_q != IDLE;
  assign cfg_cmd    = cmd_q;
  assign cfg_data   = data_q;
  assign done       = done_q;
  assign err        = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= NOP;
      data_q  <= '0;
      low_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cmd_q  <= NOP;
      data_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          err_q   <= 1'b0;
          cnt_q   <= '0;
        end
        LOAD: if (pend_q) begin
          cmd_q   <= SHIFT;
          data_q  <= low_q;
          pend_q  <= 1'b0;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= cnt_q == CW'(NIBBLES - 1) ? COMMIT : LOAD;
        end else if (acc) begin
          // a premature s_last aborts before anything from that byte reaches the chain
          if (s_last && !final_byte) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cmd_q  <= SHIFT;
            data_q <= s_data[7:4];
            low_q  <= s_data[3:0];
            pend_q <= 1'b1;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          cmd_q   <= LATCH;
          state_q <= RUN;
        end
        RUN: if (acc) begin
          cmd_q   <= EVAL;
          data_q  <= s_data[3:0];
          state_q <= s_last ? DRAIN : RUN;
        end
        DRAIN: if (empty) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  muxpga_cap_pipe #(.CAP_LAT(CAP_LAT)) u_cap (
    .clk        (clk),
    .rst        (rst),
    .launch_i   (state_q == RUN && acc),
    .fab_out_i  (fab_out),
    .cap_valid_o(cap_valid),
    .cap_data_o (cap_data),
    .empty_o    (empty)
  );
endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// tb_muxpga_cfg_loader: table-driven vectors with a capture scoreboard for the config loader
module tb_muxpga_cfg_loader;
  import muxpga_pkg::*;
  localparam int NIBBLES = 4;
  localparam int CAP_LAT = 2;
  typedef struct {logic [7:0] b; logic last; logic [7:0] exp;} vec_t;
  typedef struct {logic [7:0] d; int due;} exp_t;
  typedef struct {int c; logic [1:0] cmd; logic [3:0] d;} pin_t;
  logic clk = 0, rst, start, s_valid, s_ready, s_last, cap_valid, busy, done, err;
  logic [7:0] s_data, fab_out, cap_data;
  logic [1:0] cfg_cmd;
  logic [3:0] cfg_data;
  logic [3:0] lastv = '0;
  int cyc = 0, checks = 0, errors = 0, last_cap = 0, latch_cnt = 0, done_cnt = 0, lat0, dn0;
  vec_t tbl [6];
  exp_t sb [$];
  exp_t cur;
  pin_t plog [$];
  muxpga_cfg_loader #(.NIBBLES(NIBBLES), .CAP_LAT(CAP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .cfg_cmd(cfg_cmd), .cfg_data(cfg_data),
    .fab_out(fab_out), .cap_valid(cap_valid), .cap_data(cap_data),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] fx(input logic [3:0] v);
    return {~v, v} ^ 8'h5A;
  endfunction
  // fabric model: outputs respond to the vector present on the pins one cycle earlier
  always @(posedge clk) lastv <= cfg_data;
  assign fab_out = fx(lastv);
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (!rst && cfg_cmd != NOP) plog.push_back('{cyc, cfg_cmd, cfg_data});
    if (!rst && cfg_cmd == LATCH) latch_cnt++;
    if (done) done_cnt++;
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  always @(negedge clk) if (!rst && cap_valid) begin
    if (sb.size() == 0) chk("cap_spurious", cap_valid, 0);
    else begin
      cur = sb.pop_front();
      chk("cap_data", cap_data, cur.d);
      chk("cap_cycle", cyc, cur.due);
      last_cap = cyc;
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic l, input bit push, input logic [7:0] e);
    int n = 0;
    bit ok;
    s_valid = 1'b1; s_data = b; s_last = l;
    do begin ok = s_ready; @(negedge clk); n++; end while (!ok && n < 50);
    s_valid = 1'b0; s_last = 1'b0;
    chk("send_accept", ok, 1);
    if (push) sb.push_back('{e, cyc + CAP_LAT + 1});
  endtask
  task automatic load2(input logic [7:0] b0, input logic [7:0] b1, input int gap, input bit st);
    logic [3:0] en [5];
    plog.delete();
    if (st) begin
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_ready", s_ready, 1);
    end
    send(b0, 1'b0, 1'b0, 8'h00);
    chk("load_ready_low", s_ready, 0);
    idle(gap);
    send(b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    en = '{b0[7:4], b0[3:0], b1[7:4], b1[3:0], 4'h0};
    chk("load_len", plog.size(), 5);
    for (int i = 0; i < 5 && i < plog.size(); i++)
      chk("load_pin", {plog[i].cmd, plog[i].d}, {(i < 4) ? SHIFT : LATCH, en[i]});
    if (plog.size() >= 5) begin
      chk("nib_lo_next", plog[1].c, plog[0].c + 1);
      chk("nib_lo_next2", plog[3].c, plog[2].c + 1);
      chk("latch_next", plog[4].c, plog[3].c + 1);
    end
    chk("run_ready", s_ready, 1);
  endtask
  task automatic run_vecs(input int lo, input int hi, input int gap, input bit pstart);
    int n = 0;
    plog.delete();
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].b, tbl[i].last, 1'b1, tbl[i].exp);
      if (i < hi) begin
        if (pstart && i == lo) pulse_start();
        else idle(gap);
      end
    end
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    chk("done_cycle", cyc, last_cap + 1);
    chk("sb_empty", sb.size(), 0);
    chk("eval_count", plog.size(), hi - lo + 1);
    for (int k = 0; k < plog.size() && k <= hi - lo; k++) begin
      chk("eval_pin", {plog[k].cmd, plog[k].d}, {EVAL, tbl[lo+k].b[3:0]});
      chk("eval_cycle", plog[k].c, plog[0].c + k * (1 + gap));
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    tbl = '{'{8'h01, 1'b0, 8'h00}, '{8'h02, 1'b0, 8'h00}, '{8'h0F, 1'b1, 8'h00},
            '{8'hF7, 1'b0, 8'h00}, '{8'h3A, 1'b0, 8'h00}, '{8'hC4, 1'b1, 8'h00}};
    for (int i = 0; i < 6; i++) tbl[i].exp = fx(tbl[i].b[3:0]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd", cfg_cmd, 0);
    chk("rst_data", cfg_data, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_capv", cap_valid, 0);
    chk("rst_capd", cap_data, 0);
    load2(8'hA5, 8'h3C, 0, 1'b1);
    run_vecs(0, 2, 0, 1'b0);
    load2(8'h12, 8'h34, 2, 1'b1);
    run_vecs(3, 5, 1, 1'b1);
    plog.delete(); lat0 = latch_cnt; dn0 = done_cnt;
    pulse_start();
    send(8'h77, 1'b1, 1'b0, 8'h00);
    chk("err_set", err, 1);
    chk("err_idle", busy, 0);
    chk("err_ready", s_ready, 0);
    idle(6);
    chk("err_no_shift", plog.size(), 0);
    chk("err_no_latch", latch_cnt, lat0);
    chk("err_no_done", done_cnt, dn0);
    chk("err_sticky", err, 1);
    pulse_start();
    chk("err_clear", err, 0);
    load2(8'h5E, 8'h81, 0, 1'b0);
    run_vecs(0, 2, 0, 1'b0);
    lat0 = latch_cnt;
    pulse_start();
    send(8'h9B, 1'b0, 1'b0, 8'h00);
    chk("rst_pre_shift", {cfg_cmd, cfg_data}, {SHIFT, 4'h9});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd", cfg_cmd, 0);
    chk("mid_rst_data", cfg_data, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_capv", cap_valid, 0);
    rst = 1'b0;
    idle(3);
    chk("mid_rst_no_latch", latch_cnt, lat0);
    load2(8'hE6, 8'h0D, 1, 1'b1);
    run_vecs(3, 5, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
